// File: rtl/inv_bist_pkg.sv
// Shared definitions for the inverter BIST: FSM encoding, counter widths,
// and a saturating increment used by the mismatch counter.
// No ports; imported by inv_bist and bist_timer.
package inv_bist_pkg;

  localparam int ERR_W = 8;   // err_count width
  localparam int CNT_W = 8;   // settle counter width (SETTLE up to 255)
  localparam int RND_W = 8;   // round counter width (REPEAT up to 255)

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  localparam logic [ERR_W-1:0] ERR_MAX = '1;

  function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] val);
    return (val == ERR_MAX) ? val : val + ERR_W'(1);
  endfunction

endpackage

// File: rtl/bist_timer.sv
// Settle timer: counts cycles while count=1, cleared by load, flags terminal count.
// Latency: tc is a decode of the counter register (asserted in the cycle cnt==LIMIT-1).
// Backpressure: none; load has priority over count.
// Ports: clk, rst (async, active-high), load, count, tc.
module bist_timer
  import inv_bist_pkg::*;
#(
  parameter int LIMIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic count,
  output logic tc
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)        cnt <= '0;
    else if (load)  cnt <= '0;
    else if (count) cnt <= cnt + CNT_W'(1);
  end

  assign tc = (cnt == CNT_W'(LIMIT - 1));

endmodule

// File: rtl/inv_bist.sv
// Inverter BIST: drives 0/1 vectors to an inverter, checks each response, counts mismatches.
// Latency: a run takes REPEAT*2*(SETTLE+1) cycles from the start-sampling edge to done.
// Backpressure: start is ignored while busy; all outputs come straight from flops.
// Ports: clk, rst, start in; dut_in out / dut_out in (inverter under test);
//        busy, done, pass, err_count status out.
module inv_bist
  import inv_bist_pkg::*;
#(
  parameter int SETTLE = 4,
  parameter int REPEAT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             dut_in,
  input  logic             dut_out,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count
);

  state_t           state, state_nxt;
  logic             vec, vec_nxt;
  logic [RND_W-1:0] round, round_nxt;
  logic [ERR_W-1:0] err_nxt;
  logic             busy_d, done_d, pass_d, dut_in_d;
  logic             settle_tc;
  logic             last_round;
  logic             mismatch;

  assign last_round = (round == RND_W'(REPEAT - 1));

  // Timer sits at zero outside SETTLE so every settle phase starts from 0.
  bist_timer #(.LIMIT(SETTLE)) u_timer (
    .clk   (clk),
    .rst   (rst),
    .load  (state != ST_SETTLE),
    .count (state == ST_SETTLE),
    .tc    (settle_tc)
  );

  // State register, plus the datapath and output flops it steers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      vec       <= 1'b0;
      round     <= '0;
      err_count <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      dut_in    <= 1'b0;
    end else begin
      state     <= state_nxt;
      vec       <= vec_nxt;
      round     <= round_nxt;
      err_count <= err_nxt;
      busy      <= busy_d;
      done      <= done_d;
      pass      <= pass_d;
      dut_in    <= dut_in_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE, ST_DONE: if (start) state_nxt = ST_SETTLE;
      ST_SETTLE:        if (settle_tc) state_nxt = ST_SAMPLE;
      ST_SAMPLE:        state_nxt = (vec && last_round) ? ST_DONE : ST_SETTLE;
      default:          state_nxt = ST_IDLE;
    endcase
  end

  // Output / datapath logic. Outputs are decoded from the next state and
  // registered, so they line up with the state they describe.
  always_comb begin
    // Defaulting to mismatch makes an unknown response count as a failure.
    mismatch = 1'b1;
    if (dut_out == ~vec) mismatch = 1'b0;

    vec_nxt   = vec;
    round_nxt = round;
    err_nxt   = err_count;
    case (state)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          vec_nxt   = 1'b0;
          round_nxt = '0;
          err_nxt   = '0;
        end
      end
      ST_SAMPLE: begin
        if (mismatch) err_nxt = sat_inc(err_count);
        if (!vec) begin
          vec_nxt = 1'b1;
        end else if (!last_round) begin
          vec_nxt   = 1'b0;
          round_nxt = round + RND_W'(1);
        end
      end
      default: ;
    endcase

    busy_d   = (state_nxt == ST_SETTLE) || (state_nxt == ST_SAMPLE);
    done_d   = (state_nxt == ST_DONE);
    dut_in_d = busy_d ? vec_nxt : 1'b0;

    // pass is judged on the count that includes the final sample, then held.
    pass_d = 1'b0;
    if (state_nxt == ST_DONE)
      pass_d = (state == ST_DONE) ? pass : (err_nxt == '0);
  end

endmodule
